alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single `alu` datapath between two requesters, such as the control unit and a debug/test port. Each requester submits an operation (`alu_op`, operand A, operand B) through a valid/ready handshake. The block drives the ALU from registered operands, captures `resultAccumulator` and `flags`, and returns them to the winning requester through a valid/ready response channel. It sits between the requesters and the `alu` instance; the ALU itself stays purely combinational.

## Interface
- `W`, 16, operand/result width
- `OPW`, 5, ALU opcode width
- `FLW`, 4, ALU flag width

Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk` input 1 — clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `reqN_valid` input 1 — request N (N = 0, 1) presents an operation
- `reqN_ready` output 1 — request N accepted this cycle when high together with valid
- `reqN_op` input OPW — opcode for request N
- `reqN_a`, `reqN_b` input W — signed operands for request N
- `rspN_valid` output 1 — response for requester N is available
- `rspN_ready` input 1 — requester N consumes the response
- `rspN_result` output W — captured ALU result
- `rspN_flags` output FLW — captured ALU flags
- `alu_op` output OPW — to ALU `alu_op`
- `alu_a`, `alu_b` output W — to ALU `operandA`, `operandB`
- `alu_result` input W — from ALU `resultAccumulator`
- `alu_flags` input FLW — from ALU `flags`

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `reqN_ready` = (state==IDLE) & grantN, where the grant is computed combinationally from both valids and `last_grant`.
  - Only one ready is ever high per cycle.
  - On a handshake: latch op/a/b and owner ID, update `last_grant` to that owner, go to EXEC.
- **Round-robin:** if both valid, grant the requester other than `last_grant`; if one valid, grant it. `last_grant` resets to 1, so requester 0 wins the first contention.
- **EXEC (one cycle):**
  - `alu_op`/`alu_a`/`alu_b` are driven from the latched registers.
  - At the closing edge, capture `alu_result` and `alu_flags` into the response registers.
  - Go to RESP.
- **RESP:**
  - Only the owner's `rspN_valid` is high; result/flags are stable while valid is high.
  - The response is held until the owner's `rspN_ready` is high; then go to IDLE.
  - `rspN_ready` from the non-owner is ignored.
- **ALU drive outside EXEC:** `alu_op` = ALU_OP_IDLE (5'b00000) and operands = 0. This keeps the ALU quiet and makes flags deterministic.
- **Request inputs:** not sampled outside an IDLE handshake; requesters may change them freely.
- **Reset (including mid-EXEC or mid-RESP):**
  - State goes to IDLE; all outputs are 0; `last_grant` goes to 1.
  - An in-flight operation is discarded with no response.
  - Reset wins over a simultaneous handshake.
- No arithmetic inside the block; widths pass through unmodified. Signedness is the ALU's concern.

## Timing
- Cycle T: handshake in IDLE.
- T+1: EXEC, ALU driven.
- T+2: `rspN_valid` = 1.
- If `rspN_ready` = 1 in T+2, the response completes in T+2 and `reqN_ready` can be high again in T+3.
- Minimum: 3 cycles per operation; request-to-response latency is 2 cycles.
- Response back-pressure of k cycles stalls in RESP; no new request is accepted meanwhile.
- `reqN_ready` is combinational from state, `last_grant` and both valids. All other outputs are registered.
- Reset values: `reqN_ready`=0 during rst, `rspN_valid`=0, `rspN_result`=0, `rspN_flags`=0, `alu_op`=5'b00000, `alu_a`=`alu_b`=0.

## Structure
- Package `alu_arb_pkg`:
  - state enum (IDLE/EXEC/RESP)
  - `ALU_OP_IDLE` = 5'b00000
  - `ALU_OP_MOV` = 5'b00100 (used by the bench)
  - default W/OPW/FLW constants
- Sub-module `rr_arbiter2`: two-input round-robin grant logic with a `last_grant` register and an update-on-accept input.
- Top: FSM, operand/owner latches, response registers, ALU drive mux.

## Test plan
- **Single request.** req0 valid with op=5'b00100, a=32, b=5, against a bench ALU stub (result=a+b, flags=0) → ready0 at T, alu_op=00100 / a=32 / b=5 in T+1, rsp0_valid at T+2 with result=37. rsp1_valid stays 0.
- **Contention after reset.** Both valid (req0 a=-13 b=-3; req1 a=-9 b=1) → req0 served first (result=-16). Then req1 (result=-8). Grants alternate over 4 further back-to-back pairs.
- **Back-pressure.** rsp0_ready held low 5 cycles → result and flags stable, rsp0_valid stays high. Both readys stay 0 until the cycle after the handshake.
- **Idle drive.** No requests → alu_op=00000, alu_a=alu_b=0 every cycle. Random request-input toggling causes no state change.
- **Reset mid-operation.** rst asserted in EXEC, and separately in RESP → next cycle all outputs are 0, state is IDLE, no response for the aborted op, req0 wins the next contention.
- **Non-owner ready.** rsp1_ready asserted while RESP is owned by 0 → no effect; rsp0_valid holds until rsp0_ready.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter slice.
//   state_t      - sequencer states (IDLE, EXEC, RESP)
//   ALU_OP_IDLE  - opcode driven to the ALU whenever it is not executing
//   ALU_OP_MOV   - move opcode, handy for directed stimulus
//   DEF_*        - default operand/opcode/flag widths
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] ALU_OP_IDLE = 5'b00000;
  localparam logic [4:0] ALU_OP_MOV  = 5'b00100;

  localparam int DEF_W   = 16;
  localparam int DEF_OPW = 5;
  localparam int DEF_FLW = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant logic.
//   clk, rst  - clock and synchronous active-high reset
//   valid_i   - request valids {req1, req0}
//   accept_i  - the current grant was taken; remember its owner
//   grant_o   - one-hot (or zero) grant, combinational from valid_i and history
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) begin
      last_grant_d = grant_o[1];
    end
  end

  // Resetting to requester 1 lets requester 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   reqN_valid/ready/op/a/b     - request channel N (valid/ready handshake)
//   rspN_valid/ready/result/flags - response channel N
//   alu_op/alu_a/alu_b          - registered drive into the ALU
//   alu_result/alu_flags        - ALU outputs, captured at the end of EXEC
// Every operation takes IDLE (handshake) -> EXEC (ALU driven) -> RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int OPW = DEF_OPW,
  parameter int FLW = DEF_FLW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_result,
  output logic [FLW-1:0] rsp0_flags,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_result,
  output logic [FLW-1:0] rsp1_flags,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  input  logic [FLW-1:0] alu_flags
);

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic [OPW-1:0] op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic [FLW-1:0] flags_q, flags_d;
  logic [1:0]     rsp_valid_q, rsp_valid_d;
  logic [1:0]     grant;
  logic           handshake;
  logic           owner_ready;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (handshake),
    .grant_o  (grant)
  );

  // Readies are only offered in IDLE and never while reset is held, so a
  // requester cannot see a handshake that reset is about to discard.
  assign req0_ready = (state_q == IDLE) && !rst && grant[0];
  assign req1_ready = (state_q == IDLE) && !rst && grant[1];

  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  // The operand latches double as the ALU drive registers: they hold the
  // operation only for the EXEC cycle and are zero otherwise, so the ALU
  // sees ALU_OP_IDLE with zero operands whenever it is not working.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    rsp_valid_d = rsp_valid_q;
    handshake   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          handshake = 1'b1;
          owner_d   = grant[1];
          op_d      = grant[1] ? req1_op : req0_op;
          a_d       = grant[1] ? req1_a  : req0_a;
          b_d       = grant[1] ? req1_b  : req0_b;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result;
        flags_d     = alu_flags;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        op_d        = ALU_OP_IDLE;
        a_d         = '0;
        b_d         = '0;
        state_d     = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
  end

  // Reset discards any in-flight operation and clears every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      op_q        <= ALU_OP_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_flags  = flags_q;
  assign rsp1_flags  = flags_q;

endmodule
